bram_arbiter: RTL
=================

Name: bram_arbiter

Overview:
- Shares the single-port testbench/system BRAM between two requesters: instruction fetch (port I) and load/store (port D).
- Each port uses the same valid/instr/addr/wdata/wstrb -> rdata/ready protocol as the BRAM.
- Per-port one-entry request buffers capture single-cycle valid pulses; an FSM issues one access at a time downstream and routes the response back to its owner.
- Sits between the core's fetch/LSU memory ports and the BRAM.

Parameters:
- PRIO_MODE, 0, grant policy when both buffers are pending: 0 = round-robin; 1 = fixed priority to port D.

Ports:
- rst  input  1  asynchronous active-low reset
- clk  input  1  clock
- imem_valid  input  1  port I request pulse
- imem_instr  input  1  port I instruction-access flag
- imem_addr  input  32  port I byte address
- imem_wdata  input  32  port I write data
- imem_wstrb  input  4  port I byte strobes (0 = read)
- imem_rdata  output  32  port I read data
- imem_ready  output  1  port I completion pulse
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb, dmem_rdata, dmem_ready: same as port I, for port D
- bram_valid  output  1  downstream request pulse
- bram_instr  output  1  downstream instruction flag
- bram_addr  output  32  downstream address
- bram_wdata  output  32  downstream write data
- bram_wstrb  output  4  downstream strobes
- bram_rdata  input  32  downstream read data
- bram_ready  input  1  downstream completion

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; both buffers cleared; rr pointer = I (next tie goes to I).
  - bram_valid, bram_instr, bram_wstrb, bram_addr, bram_wdata = 0.
  - imem_ready = dmem_ready = 0; imem_rdata = dmem_rdata = 0.
- Capture: Xmem_valid=1 at a clk edge loads buffer X (instr, addr, wdata, wstrb) and sets pend_X. Both ports can capture in the same cycle.
- Protocol: a requester must not pulse valid again before its ready. A valid while pend_X or owner==X is ignored, and the simulation assertion "bram_arbiter: overlap on X" fires.
- FSM states:
  - IDLE: if any pend, select a winner, go to ISSUE.
  - ISSUE: bram_valid=1 for exactly one cycle, carrying the winner's fields as registered outputs; clear pend_winner; go to WAIT.
  - WAIT: hold until bram_ready=1. On that cycle:
    - Xmem_ready = 1 and Xmem_rdata = bram_rdata (registered), both in the same cycle as bram_ready, for owner X only.
    - The other port's ready stays 0 and its rdata holds its last value.
    - Next state is ISSUE if any pend remains (including a capture in this same cycle), otherwise IDLE.
- Selection:
  - PRIO_MODE=0: if only one port is pending, grant it. If both, grant the port named by rr; rr flips to the other port after each grant.
  - PRIO_MODE=1: D always wins ties.
- Latency:
  - Isolated request: valid at edge t, bram_valid in cycle t+1, bram_ready in t+2, Xmem_ready in t+2. Two cycles total.
  - Back-to-back throughput: one access per 2 cycles.
- Write-only and read accesses are treated identically; ready is returned for both.
- Outputs with bram_valid=0: bram_* fields hold their last values, but bram_wstrb is forced to 0.
- Reset during ISSUE or WAIT: the outstanding access is abandoned and no ready is produced. A bram_ready arriving after reset is ignored (FSM in IDLE).

Decomposition:
- Package configure:
  - typedef mem_req_t {instr, addr[31:0], wdata[31:0], wstrb[3:0]}
  - typedef arb_state_t {IDLE, ISSUE, WAIT}
  - constants PORT_I=0, PORT_D=1
- Sub-module bram_arbiter_buf: one-entry request buffer (capture, pend flag, clear), instantiated once per port.

Test Plan:
- Single read: imem_valid pulse, addr=0x100, wstrb=0, BRAM word 0x00000013 -> bram_valid in t+1 with addr 0x100; imem_ready and imem_rdata=0x00000013 in t+2; dmem_ready stays 0.
- Simultaneous requests, PRIO_MODE=0, after reset: I addr 0x0 and D addr 0x200 in the same cycle -> I issued first (ready t+2), D issued t+3 (ready t+4); repeat -> D first.
- Same case with PRIO_MODE=1 -> D serviced first on both repetitions.
- D write addr 0x204, wdata 0xDEADBEEF, wstrb 0x3, then D read 0x204 (word previously 0) -> read returns 0x0000BEEF.
- Capture during WAIT: D pulse lands in I's bram_ready cycle -> D ISSUE in the next cycle with no IDLE gap.
- Reset asserted in WAIT -> all outputs 0 immediately (before the next clk edge); no ready after release; a fresh request then completes normally in 2 cycles.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared types and constants for the BRAM arbiter
//
// Contents:
//   mem_req_t   : one captured memory request (instr, addr, wdata, wstrb)
//   arb_state_t : arbiter FSM states
//   PORT_I/D    : port indices used for owner and round-robin pointer
package bram_arbiter_pkg;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/bram_arbiter_buf.sv
// rtl/bram_arbiter_buf.sv - one-entry request buffer for a single arbiter port
//
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   i_capture  : load i_req and set the pending flag
//   i_req      : request fields presented by the port
//   i_clear    : drop the pending flag (request granted)
//   o_pend     : a request is waiting for a grant
//   o_req      : the buffered request fields
module bram_arbiter_buf
  import bram_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_capture,
  input  mem_req_t i_req,
  input  logic     i_clear,
  output logic     o_pend,
  output mem_req_t o_req
);

  logic     r_pend;
  mem_req_t r_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_req  <= '0;
    end else begin
      if (i_capture) begin
        r_req <= i_req;
      end
      // Clear wins over capture: both on the same edge means the incoming
      // request was granted straight through without waiting in the buffer.
      if (i_clear) begin
        r_pend <= 1'b0;
      end else if (i_capture) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_req  = r_req;

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares one single-port BRAM between fetch (I) and load/store (D)
//
// Ports:
//   rst, clk                : asynchronous active-low reset, clock
//   imem_* (valid/instr/addr/wdata/wstrb -> rdata/ready) : port I requester
//   dmem_* (same)           : port D requester
//   bram_* (valid/instr/addr/wdata/wstrb <- rdata/ready) : downstream BRAM
// Parameters:
//   PRIO_MODE : 0 = round-robin on ties, 1 = port D always wins ties
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready
);

  arb_state_t  r_state;
  logic        r_owner;
  logic        r_rr;
  logic        r_bvalid;
  logic        r_binstr;
  logic [31:0] r_baddr;
  logic [31:0] r_bwdata;
  logic [3:0]  r_bwstrb;
  logic [31:0] r_irdata;
  logic [31:0] r_drdata;

  mem_req_t w_i_in, w_d_in, w_i_buf, w_d_buf, w_i_eff, w_d_eff, w_win_req;
  logic     w_i_pend, w_d_pend;
  logic     w_done, w_i_busy, w_d_busy, w_i_cap, w_d_cap;
  logic     w_pi, w_pd, w_any, w_tie, w_win, w_issue, w_i_clr, w_d_clr;

  assign w_i_in = '{instr: imem_instr, addr: imem_addr, wdata: imem_wdata, wstrb: imem_wstrb};
  assign w_d_in = '{instr: dmem_instr, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  // The completing access is finished on this edge, so its owner is no
  // longer considered busy and may have a new request captured.
  assign w_done   = (r_state == WAIT) && bram_ready;
  assign w_i_busy = (r_state != IDLE) && (r_owner == PORT_I) && !w_done;
  assign w_d_busy = (r_state != IDLE) && (r_owner == PORT_D) && !w_done;
  assign w_i_cap  = imem_valid && !w_i_pend && !w_i_busy;
  assign w_d_cap  = dmem_valid && !w_d_pend && !w_d_busy;

  // On the completion edge a request arriving in that same cycle is eligible
  // for the next grant, so back-to-back traffic never passes through IDLE.
  assign w_pi    = w_i_pend || (w_done && w_i_cap);
  assign w_pd    = w_d_pend || (w_done && w_d_cap);
  assign w_i_eff = w_i_pend ? w_i_buf : w_i_in;
  assign w_d_eff = w_d_pend ? w_d_buf : w_d_in;

  always_comb begin
    w_any = w_pi || w_pd;
    w_tie = w_pi && w_pd;
    w_win = PORT_I;
    if (w_tie) begin
      w_win = (PRIO_MODE == 1) ? PORT_D : r_rr;
    end else if (w_pd) begin
      w_win = PORT_D;
    end
    w_win_req = (w_win == PORT_D) ? w_d_eff : w_i_eff;
  end

  assign w_issue = ((r_state == IDLE) || w_done) && w_any;
  assign w_i_clr = w_issue && (w_win == PORT_I);
  assign w_d_clr = w_issue && (w_win == PORT_D);

  bram_arbiter_buf u_buf_i (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_i_cap),
    .i_req     (w_i_in),
    .i_clear   (w_i_clr),
    .o_pend    (w_i_pend),
    .o_req     (w_i_buf)
  );

  bram_arbiter_buf u_buf_d (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_d_cap),
    .i_req     (w_d_in),
    .i_clear   (w_d_clr),
    .o_pend    (w_d_pend),
    .o_req     (w_d_buf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= PORT_I;
      r_rr     <= PORT_I;
      r_bvalid <= 1'b0;
      r_binstr <= 1'b0;
      r_baddr  <= '0;
      r_bwdata <= '0;
      r_bwstrb <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      assert (!imem_valid || w_i_cap) else $error("bram_arbiter: overlap on I");
      assert (!dmem_valid || w_d_cap) else $error("bram_arbiter: overlap on D");

      if (w_done) begin
        if (r_owner == PORT_I) begin
          r_irdata <= bram_rdata;
        end else begin
          r_drdata <= bram_rdata;
        end
      end

      if (w_issue) begin
        r_state  <= ISSUE;
        r_owner  <= w_win;
        r_bvalid <= 1'b1;
        r_binstr <= w_win_req.instr;
        r_baddr  <= w_win_req.addr;
        r_bwdata <= w_win_req.wdata;
        r_bwstrb <= w_win_req.wstrb;
        // Only contested grants advance the round-robin pointer.
        if (w_tie && (PRIO_MODE == 0)) begin
          r_rr <= ~r_rr;
        end
      end else begin
        case (r_state)
          ISSUE: begin
            r_state  <= WAIT;
            r_bvalid <= 1'b0;
            r_bwstrb <= '0;
          end
          WAIT: begin
            if (bram_ready) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bram_valid = r_bvalid;
  assign bram_instr = r_binstr;
  assign bram_addr  = r_baddr;
  assign bram_wdata = r_bwdata;
  assign bram_wstrb = r_bwstrb;

  // Ready and data are returned in the BRAM's own ready cycle; the rdata
  // register keeps the last value for the port afterwards.
  assign imem_ready = w_done && (r_owner == PORT_I);
  assign dmem_ready = w_done && (r_owner == PORT_D);
  assign imem_rdata = imem_ready ? bram_rdata : r_irdata;
  assign dmem_rdata = dmem_ready ? bram_rdata : r_drdata;

endmodule
